serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Downstream consumer of the team's serial shift-register stage. Takes its 1-bit serial output stream.
- Hunts for a fixed sync pattern, then assembles a DATA_W-bit payload MSB-first and checks an even-parity bit.
- Presents each good word on a registered valid/ready parallel interface.
- Sits between the serial line stages and the byte-wide datapath.

Parameters:
- DATA_W, 8, payload width in bits (>=2)
- SYNC_W, 4, sync pattern length in bits (>=2)
- SYNC_PATTERN, 4'b1011, sync word, SYNC_W bits, first-received bit in the MSB position

Ports:
- clk  input  1  clock
- rst  input  1  reset
- srl_in  input  1  serial data bit from the upstream shift stage
- bit_en  input  1  qualifies srl_in; a bit is consumed only on cycles with bit_en=1
- data_out  output  DATA_W  assembled payload, MSB = first received payload bit
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts the word when data_valid && data_ready
- parity_err  output  1  1-cycle pulse: frame failed parity, word discarded
- overrun  output  1  1-cycle pulse: good frame dropped because the output slot was full
- busy  output  1  FSM not in HUNT

Behaviour:
- Reset: rst synchronous, active-high; clock clk; all flops update on the rising edge of clk.
- On rst: state=HUNT, sync window=0, bit counter=0, data_out=0, data_valid=0, parity_err=0, overrun=0, busy=0.
- rst mid-frame aborts the frame, with no parity_err and no overrun pulse. A pending output word is discarded.
- FSM states: HUNT, DATA, PARITY.
- All state changes occur only on cycles with bit_en=1, except output handshake and pulse clearing.
- HUNT:
  - Shift srl_in into the SYNC_W-bit window (new bit at LSB).
  - If {window[SYNC_W-2:0], srl_in} == SYNC_PATTERN: go to DATA, counter=0, clear the window.
  - Otherwise stay; overlapping matches are allowed.
- DATA:
  - Shift srl_in into the payload shift register; counter++.
  - When counter == DATA_W-1 on a bit_en cycle, go to PARITY.
- PARITY:
  - Received bit p. Frame good iff XOR(payload, p) == 0, i.e. even parity.
  - Always return to HUNT.
- Completion, on the PARITY bit_en cycle; effects visible next cycle:
  - Bad parity: parity_err=1 for one cycle; word dropped; data_valid unchanged.
  - Good, slot free (data_valid=0, or data_valid && data_ready this same cycle): data_out loaded, data_valid=1.
  - Good, slot full with no handshake this cycle: word dropped; overrun=1 for one cycle; the held data_out is kept.
- Latency: data_valid rises 1 clk after the parity bit's bit_en cycle.
- Handshake:
  - data_valid && data_ready clears data_valid next cycle, unless a simultaneous completion reloads it.
  - data_out is stable while data_valid=1.
- bit_en=0 cycles freeze the FSM, counter and window; the handshake still operates.
- Minimum frame: SYNC_W + DATA_W + 1 bit_en cycles; back-to-back frames are supported.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_EN.
- Defined: PARITY state and parity check exactly as above.
- Undefined:
  - No parity bit on the line; DATA goes straight to completion on its last bit and returns to HUNT.
  - The frame is always good; parity_err is tied to 0.
  - Minimum frame becomes SYNC_W + DATA_W.

Decomposition:
- Package serial_frame_pkg:
  - state enum (HUNT, DATA, PARITY)
  - default SYNC_W / SYNC_PATTERN constants
  - counter width function clog2(DATA_W)
- Sub-module frame_sync_det: SYNC_W window shift register plus comparator.
  - Inputs: clk, rst, bit_in, bit_en, clr.
  - Output: match (combinational on the current bit).
- Everything else lives in serial_frame_rx.

Test Plan:
- After rst, feed 1,0,1,1 then 1,0,1,0,0,1,0,1 (0xA5), parity 0 with bit_en=1 each cycle, data_ready=1 -> data_valid=1 for one cycle, data_out=0xA5, parity_err=0.
- Same frame with parity 1 -> parity_err pulses once; data_valid stays 0.
- Noise 1,1,0,1,0,1,1 (overlapping sync), then 0x3C + parity 0 -> sync locks at the 7th bit; data_out=0x3C.
- data_ready=0; send 0x11 then 0x22, both good -> data_out stays 0x11, overrun pulses once. Then ready=1 -> 0x11 accepted, data_valid=0.
- Assert rst after 4 payload bits of a frame, then send a full 0x5A frame -> first frame lost with no pulses; data_out=0x5A.
- bit_en toggling 1/0 every cycle during a 0xC3 frame -> same result as contiguous input; data_valid rises 1 clk after the parity bit's bit_en cycle.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and constants for the serial frame receiver
//
// Purpose : FSM state encoding, default sync-word constants and the counter
//           width helper used by serial_frame_rx and frame_sync_det.
// Ports   : none (package)
package serial_frame_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int                    SYNC_W_DEF       = 4;
   localparam logic [SYNC_W_DEF-1:0] SYNC_PATTERN_DEF = 4'b1011;

   // Bits needed to count 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/frame_sync_det.sv
// rtl/frame_sync_det.sv - sync-word window shift register and comparator
//
// Purpose : keeps the last SYNC_W-1 qualified bits and flags when they,
//           together with the bit currently on the line, form the sync word.
// Ports   : clk, rst    - clock, synchronous active-high reset
//           bit_in      - current serial bit
//           bit_en      - shift bit_in into the window this cycle
//           clr         - zero the window (takes priority over bit_en)
//           match       - combinational: {window, bit_in} equals SYNC_PATTERN
module frame_sync_det
   import serial_frame_pkg::*;
#(
   parameter int                SYNC_W       = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_in,
   input  logic bit_en,
   input  logic clr,
   output logic match
);

   logic [SYNC_W-1:0] window_q;
   logic [SYNC_W-1:0] window_d;
   logic [SYNC_W-1:0] candidate;

   // The oldest window bit falls off as the new bit arrives, so the
   // comparison uses the window shifted by one plus the live bit.
   assign candidate = {window_q[SYNC_W-2:0], bit_in};
   assign match     = (candidate == SYNC_PATTERN);

   always_comb begin
      window_d = window_q;
      if (clr) begin
         window_d = '0;
      end else if (bit_en) begin
         window_d = candidate;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         window_q <= '0;
      end else begin
         window_q <= window_d;
      end
   end

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - sync-hunting serial frame receiver with valid/ready output
//
// Purpose : hunts for SYNC_PATTERN on the qualified serial stream, assembles a
//           DATA_W-bit payload MSB-first and, when SERIAL_FRAME_RX_PARITY_EN
//           is defined, checks a trailing even-parity bit. Good words are
//           offered on a registered single-slot valid/ready interface.
// Macro   : SERIAL_FRAME_RX_PARITY_EN - defined: frames carry a parity bit.
//           Undefined: no parity bit, every frame is good, parity_err = 0.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           srl_in       - serial data bit
//           bit_en       - srl_in is consumed only when 1
//           data_out     - payload, MSB = first received payload bit
//           data_valid   - data_out holds an unconsumed word
//           data_ready   - consumer takes the word when data_valid is high
//           parity_err   - one-cycle pulse, frame failed parity and was dropped
//           overrun      - one-cycle pulse, good frame dropped, slot was full
//           busy         - receiver is inside a frame (not hunting)
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int                DATA_W       = 8,
   parameter int                SYNC_W       = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              srl_in,
   input  logic              bit_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              parity_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CNT_W = clog2(DATA_W);

   state_t              state_q,      state_d;
   logic [CNT_W-1:0]    cnt_q,        cnt_d;
   logic [DATA_W-1:0]   shreg_q,      shreg_d;
   logic [DATA_W-1:0]   data_out_q,   data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                parity_err_q, parity_err_d;
   logic                overrun_q,    overrun_d;

   logic                sync_match;
   logic                sync_shift;
   logic                sync_clr;
   logic                complete;
   logic                frame_good;
   logic [DATA_W-1:0]   frame_word;

   // The window only moves while hunting; it is zeroed on lock so the next
   // hunt starts from a clean slate after the frame.
   assign sync_shift = bit_en && (state_q == HUNT);
   assign sync_clr   = sync_shift && sync_match;

   frame_sync_det #(
      .SYNC_W       (SYNC_W),
      .SYNC_PATTERN (SYNC_PATTERN)
   ) u_sync_det (
      .clk    (clk),
      .rst    (rst),
      .bit_in (srl_in),
      .bit_en (sync_shift),
      .clr    (sync_clr),
      .match  (sync_match)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shreg_d      = shreg_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
      complete     = 1'b0;
      frame_good   = 1'b0;
      frame_word   = shreg_q;

      if (data_valid_q && data_ready) begin
         data_valid_d = 1'b0;
      end

      case (state_q)
         HUNT: begin
            if (bit_en && sync_match) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end

         DATA: begin
            if (bit_en) begin
               shreg_d = {shreg_q[DATA_W-2:0], srl_in};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  state_d = PARITY;
`else
                  // No parity bit on the line: the last payload bit
                  // completes the frame directly.
                  state_d    = HUNT;
                  complete   = 1'b1;
                  frame_good = 1'b1;
                  frame_word = shreg_d;
`endif
               end
            end
         end

         PARITY: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            if (bit_en) begin
               state_d    = HUNT;
               complete   = 1'b1;
               frame_good = ~(^{shreg_q, srl_in});
            end
`else
            state_d = HUNT;
`endif
         end

         default: begin
            state_d = HUNT;
         end
      endcase

      // A same-cycle handshake frees the slot, so a completing word may
      // replace the one being taken.
      if (complete) begin
         if (!frame_good) begin
            parity_err_d = 1'b1;
         end else if (!data_valid_q || data_ready) begin
            data_out_d   = frame_word;
            data_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         cnt_q        <= '0;
         shreg_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shreg_q      <= shreg_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != HUNT);

endmodule
